// File: rtl/draw_dstunpack.sv
`timescale 1ns/1ps
// draw_dstunpack: pops 64-bit destination words from the pixel buffer
// FIFO and hands them to the blend stage one 16-bit pixel at a time.
module draw_dstunpack #(
  parameter int CNTW = 12
) (
  input  logic            CLK,
  input  logic            RST_X,
  input  logic            INIT,
  input  logic            START,
  input  logic [CNTW-1:0] PIXCNT,
  input  logic [1:0]      XOFS,
  input  logic [63:0]     BUF_DATA,
  input  logic            BUF_DATAVALID,
  input  logic            BUF_EMPTY,
  output logic            BUF_RD,
  output logic [15:0]     PIX_OUT,
  output logic            PIX_VALID,
  input  logic            PIX_READY,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_FIN
  } state_t;

  state_t          r_state;
  logic [63:0]     r_word;
  logic [1:0]      r_lane;
  logic [CNTW-1:0] r_remain;
  logic            r_first;
  logic [1:0]      r_ofs;
  logic            r_err;
  // High for the one cycle after reset/INIT, so a read-data beat still
  // in flight from an abandoned span is not mistaken for a protocol error.
  logic            r_ign;

  logic            w_rd;
  logic            w_hs;
  logic [15:0]     w_pix;

  // FIFO strobe and pixel handshake decode
  always_comb begin
    w_rd = (r_state == S_FETCH) & ~BUF_EMPTY & ~INIT;
    w_hs = (r_state == S_EMIT) & PIX_READY;
  end

  // Lane select out of the held word; zero when no pixel is offered
  always_comb begin
    w_pix = '0;
    if (r_state == S_EMIT) begin
      w_pix = r_word[16*r_lane +: 16];
    end
  end

  // Span sequencer, word/lane registers and sticky error
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state  <= S_IDLE;
      r_word   <= '0;
      r_lane   <= '0;
      r_remain <= '0;
      r_first  <= 1'b0;
      r_ofs    <= '0;
      r_err    <= 1'b0;
      r_ign    <= 1'b1;
    end else if (INIT) begin
      r_state  <= S_IDLE;
      r_word   <= '0;
      r_lane   <= '0;
      r_remain <= '0;
      r_first  <= 1'b0;
      r_ofs    <= '0;
      r_err    <= 1'b0;
      r_ign    <= 1'b1;
    end else begin
      r_ign <= 1'b0;
      if (BUF_DATAVALID && r_state != S_WAIT && !r_ign) begin
        r_err <= 1'b1;
      end
      if (START && r_state != S_IDLE) begin
        r_err <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (START) begin
            if (PIXCNT != '0) begin
              r_remain <= PIXCNT;
              r_ofs    <= XOFS;
              r_first  <= 1'b1;
              r_state  <= S_FETCH;
            end else begin
              r_state  <= S_FIN;
            end
          end
        end
        S_FETCH: begin
          if (w_rd) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (BUF_DATAVALID) begin
            r_word  <= BUF_DATA;
            r_lane  <= r_first ? r_ofs : 2'd0;
            r_first <= 1'b0;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_hs) begin
            r_remain <= r_remain - CNTW'(1);
            r_lane   <= r_lane + 2'd1;
            if (r_remain == CNTW'(1)) begin
              r_state <= S_FIN;
            end else if (r_lane == 2'd3) begin
              r_state <= S_FETCH;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BUF_RD    = w_rd;
  assign PIX_OUT   = w_pix;
  assign PIX_VALID = (r_state == S_EMIT);
  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = (r_state == S_FIN);
  assign ERR       = r_err;

endmodule
